// File: rtl/iic_target_regmap.sv
// I2C target with a byte register map, auto-increment pointer and a
// maskable clear-on-read interrupt source register.
module iic_target_regmap #(
  parameter logic [6:0] DEVICE_ADDRESS = 7'h53,
  parameter int         REG_COUNT      = 64,
  parameter logic [7:0] ID_VALUE       = 8'hE5,
  parameter logic [7:0] IRQ_EN_ADDR    = 8'h2E,
  parameter logic [7:0] IRQ_SRC_ADDR   = 8'h30,
  parameter int         STRETCH_CYCLES = 0
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       IIC_SCL_I,
  input  logic       IIC_SDA_I,
  output logic       IIC_SCL_O,
  output logic       IIC_SDA_O,
  input  logic [7:0] SET_IRQ_SRC,
  output logic       IRQ
);

  localparam int AW = (REG_COUNT > 2) ? $clog2(REG_COUNT) : 1;
  localparam int SW = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES + 1) : 1;
  localparam logic [AW-1:0] EN_I  = AW'(IRQ_EN_ADDR);
  localparam logic [AW-1:0] SRC_I = AW'(IRQ_SRC_ADDR);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK,
    WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  state_t        state;
  logic          scl_q, sda_q;
  logic [3:0]    cnt;
  logic [7:0]    sr, ptr, tx;
  logic          rw, ackd, mack, tx_src;
  logic [SW-1:0] scnt;
  logic [7:0]    regs [REG_COUNT];

  logic       scl_rise, scl_fall, start, stop;
  logic       rx_state, byte_done, in_rng, writable, clr;
  logic [7:0] rx, rd, ptr_nxt, src_nxt;

  assign scl_rise  = IIC_SCL_I & ~scl_q;
  assign scl_fall  = ~IIC_SCL_I & scl_q;
  assign start     = IIC_SCL_I & scl_q & sda_q & ~IIC_SDA_I;
  assign stop      = IIC_SCL_I & scl_q & ~sda_q & IIC_SDA_I;
  assign rx        = {sr[6:0], IIC_SDA_I};
  assign rx_state  = (state == ADDR) || (state == PTR) ||
                     (state == WDATA);
  assign byte_done = rx_state && scl_rise && (cnt == 4'd7);
  assign in_rng    = {1'b0, ptr} < 9'(REG_COUNT);
  assign rd        = in_rng ? regs[ptr[AW-1:0]] : 8'h00;
  assign ptr_nxt   = (ptr == 8'(REG_COUNT - 1)) ? 8'h00
                                                : ptr + 8'd1;
  assign writable  = in_rng && (ptr != 8'h00) &&
                     (ptr != IRQ_SRC_ADDR);
  // Host set strobes dominate the read-side clear
  assign clr       = (state == RDATA_ACK) && scl_rise && tx_src;
  assign src_nxt   = (regs[SRC_I] & ~(clr ? tx : 8'h00)) |
                     SET_IRQ_SRC;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
      cnt       <= 4'd0;
      sr        <= 8'h00;
      ptr       <= 8'h00;
      tx        <= 8'h00;
      rw        <= 1'b0;
      ackd      <= 1'b0;
      mack      <= 1'b0;
      tx_src    <= 1'b0;
      scnt      <= '0;
      IIC_SCL_O <= 1'b1;
      IIC_SDA_O <= 1'b1;
      IRQ       <= 1'b0;
      for (int i = 0; i < REG_COUNT; i++)
        regs[i] <= (i == 0) ? ID_VALUE : 8'(i);
    end else begin
      scl_q       <= IIC_SCL_I;
      sda_q       <= IIC_SDA_I;
      IRQ         <= |(regs[SRC_I] & regs[EN_I]);
      regs[SRC_I] <= src_nxt;
      if (scnt != '0) begin
        scnt <= scnt - SW'(1);
        if (scnt == SW'(1)) IIC_SCL_O <= 1'b1;
      end
      if (start || stop) begin
        state     <= start ? ADDR : IDLE;
        cnt       <= 4'd0;
        ackd      <= 1'b0;
        mack      <= 1'b0;
        scnt      <= '0;
        IIC_SDA_O <= 1'b1;
        IIC_SCL_O <= 1'b1;
      end else begin
        if (rx_state && scl_rise) begin
          sr  <= rx;
          cnt <= byte_done ? 4'd0 : cnt + 4'd1;
        end
        unique case (state)
          IDLE: begin end
          ADDR: if (byte_done) begin
            ackd <= 1'b0;
            if (rx[7:1] == DEVICE_ADDRESS) begin
              rw    <= rx[0];
              state <= ADDR_ACK;
            end else begin
              state <= IDLE;
            end
          end
          PTR: if (byte_done) begin
            ptr   <= rx;
            ackd  <= 1'b0;
            state <= PTR_ACK;
          end
          WDATA: if (byte_done) begin
            if (writable) regs[ptr[AW-1:0]] <= rx;
            ptr   <= ptr_nxt;
            ackd  <= 1'b0;
            state <= WDATA_ACK;
          end
          ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
            // first fall opens the ACK bit, second one closes it
            if (!ackd) begin
              IIC_SDA_O <= 1'b0;
              ackd      <= 1'b1;
            end else begin
              ackd      <= 1'b0;
              IIC_SDA_O <= 1'b1;
              if (STRETCH_CYCLES > 0) begin
                IIC_SCL_O <= 1'b0;
                scnt      <= SW'(STRETCH_CYCLES);
              end
              if (state == ADDR_ACK && rw) begin
                tx        <= rd;
                tx_src    <= (ptr == IRQ_SRC_ADDR);
                sr        <= {rd[6:0], 1'b0};
                IIC_SDA_O <= rd[7];
                cnt       <= 4'd0;
                state     <= RDATA;
              end else begin
                state <= (state == ADDR_ACK) ? PTR : WDATA;
              end
            end
          end
          RDATA: begin
            if (scl_rise) cnt <= cnt + 4'd1;
            if (scl_fall) begin
              if (cnt == 4'd8) begin
                IIC_SDA_O <= 1'b1;
                mack      <= 1'b0;
                state     <= RDATA_ACK;
              end else begin
                IIC_SDA_O <= sr[7];
                sr        <= {sr[6:0], 1'b0};
              end
            end
          end
          RDATA_ACK: begin
            if (scl_rise) begin
              ptr <= ptr_nxt;
              if (IIC_SDA_I) state <= IDLE;
              else           mack  <= 1'b1;
            end
            if (scl_fall && mack) begin
              mack      <= 1'b0;
              tx        <= rd;
              tx_src    <= (ptr == IRQ_SRC_ADDR);
              sr        <= {rd[6:0], 1'b0};
              IIC_SDA_O <= rd[7];
              cnt       <= 4'd0;
              state     <= RDATA;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/iic_target_regmap.md
Name: iic_target_regmap

Overview:
- Parametrised simulation/FPGA I2C target (slave) model, successor to the fixed-map single-mode sensor imitator.
- Sits on the bench side of the IIC pins opposite the ADXL345 master controller.
- Supports write and read transfers, repeated START, address match/NACK, and a configurable register map with auto-increment and wrap.
- Provides a maskable interrupt register pair with clear-on-read, plus a host backdoor for setting interrupt sources.

Parameters:
- DEVICE_ADDRESS, 7'h53: 7-bit target address; any other address is NACKed.
- REG_COUNT, 64: number of 8-bit registers, 2..256; reset image reg[i]=i.
- ID_VALUE, 8'hE5: reset value of reg[0]; reg[0] is read-only.
- IRQ_EN_ADDR, 8'h2E: interrupt-enable register index.
- IRQ_SRC_ADDR, 8'h30: interrupt-source register index; read-only over I2C, clear-on-read.
- STRETCH_CYCLES, 0: clk cycles IIC_SCL_O is held low after each ACK-bit SCL falling edge; 0 disables stretching.

Ports:
- clk  in  1  single clock, must be at least 8x SCL.
- resetn  in  1  synchronous, active-low reset.
- IIC_SCL_I  in  1  sampled SCL.
- IIC_SDA_I  in  1  sampled SDA.
- IIC_SCL_O  out  1  open-drain SCL: 0 = pull low (stretch), 1 = release.
- IIC_SDA_O  out  1  open-drain SDA: 0 = pull low, 1 = release.
- SET_IRQ_SRC  in  8  per-bit one-cycle set strobes, ORed into reg[IRQ_SRC_ADDR].
- IRQ  out  1  interrupt, active high.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Values on reset (resetn=0 at a clk edge):
  - IIC_SCL_O=1, IIC_SDA_O=1, IRQ=0.
  - Register image reloaded; state IDLE; ptr=0; bit counter=0.
- Edge detection: SCL and SDA registered once.
  - scl_rise and scl_fall are 1-cycle pulses.
  - START: SDA falls while SCL=1. STOP: SDA rises while SCL=1.
  - START or STOP in any state: bit counter=0, state to ADDR (START) or IDLE (STOP), IIC_SDA_O=1 within 1 clk. This covers repeated START.
- Data sampling: SDA is sampled MSB-first on scl_rise. After 8 bits, a byte is complete.
  - SDA changes are driven only on the clk after scl_fall.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
- ADDR:
  - If the address matches: drive ACK (SDA_O=0) for the 9th SCL period. Go to PTR if R/W=0, or RDATA if R/W=1.
  - Otherwise: keep SDA released and go to IDLE; the target ignores the bus until the next START.
- PTR: the received byte loads ptr, then ACK; next state WDATA.
- WDATA, each byte:
  - Write reg[ptr] if ptr<REG_COUNT and ptr is not 0 or IRQ_SRC_ADDR.
  - ACK always.
  - Advance ptr: ptr=(ptr==REG_COUNT-1)?0:ptr+1. A ptr value >= REG_COUNT increments without wrap until 8-bit overflow.
- RDATA:
  - Shift out reg[ptr] MSB-first. Out-of-range ptr returns 8'h00.
  - Release SDA during the master ACK bit and sample it on scl_rise.
  - Master ACK (0): ptr advances as in WDATA and the next byte is sent.
  - Master NACK (1): SDA stays released; go to IDLE and wait for STOP or START.
- Clear-on-read:
  - If the byte just sent came from IRQ_SRC_ADDR, those bits clear when the master ACK/NACK bit is sampled.
  - A SET_IRQ_SRC bit in the same cycle wins (set dominates clear).
- IRQ: registered, 1-cycle latency; IRQ = |(reg[IRQ_SRC_ADDR] & reg[IRQ_EN_ADDR]).
- Stretch: when STRETCH_CYCLES>0, after scl_fall ending each target-ACK bit, IIC_SCL_O=0 for exactly STRETCH_CYCLES clk. SDA is set up for the next bit during the stretch.
- Reset mid-transfer: immediate abort; outputs return to reset values on the next clk.

Test Plan:
- Read ID: S, 0xA6, ptr 0x00, Sr, 0xA7, read 1 byte, NACK, P -> address ACK seen twice; data 0xE5; SDA released after NACK.
- Burst write then read:
  - Write 0x1D with 0x11,0x22,0x33 -> all ACKed.
  - Read back from 0x1D, 3 bytes -> 0x11,0x22,0x33; ptr ends at 0x20.
- Address mismatch: S, 0x3A -> no ACK (SDA_O=1 throughout); a subsequent valid transfer works normally.
- Wrap and protection, with REG_COUNT=64:
  - Write 0x3F then 0xAA,0xBB -> reg[63]=0xAA; reg[0] keeps 0xE5 while the byte is still ACKed.
  - Read 0x3F, 2 bytes -> 0xAA,0xE5.
- IRQ:
  - Write 0x2E=0x80, pulse SET_IRQ_SRC=0x80 -> IRQ=1 one clk later.
  - Read 0x30 -> byte 0x80; IRQ=0 after the ACK bit.
  - Set pulse coincident with the clearing ACK bit -> IRQ stays 1.
- STRETCH_CYCLES=20: every ACK bit is followed by SCL_O=0 for exactly 20 clk.
- Reset mid-read: resetn low mid-byte -> SDA_O=1 next clk.
